// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and command layout for the two-master round-robin bus arbiter.
package rr_bus_arbiter_pkg;

    localparam int unsigned CMD_ADDR_W    = 3;
    localparam int unsigned CMD_DATA_W    = 3;
    localparam int unsigned CMD_W         = CMD_ADDR_W + CMD_DATA_W + 1;
    localparam int unsigned CMD_VALUE_LSB = 0;
    localparam int unsigned CMD_ADDR_LSB  = CMD_DATA_W;
    localparam int unsigned CMD_SEL_BIT   = CMD_ADDR_W + CMD_DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic                  sel;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] value;
    } cmd_t;

endpackage

// File: rtl/rr_req_slot.sv
// One-deep command slot per master: captures a strobe when free, flags drops when busy.
module rr_req_slot
    import rr_bus_arbiter_pkg::*;
#(
    parameter int unsigned W = CMD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         clear_i,
    output logic         busy_o,
    output logic         drop_o,
    output logic [W-1:0] cmd_o
);

    logic         pending_q;
    logic         drop_q;
    logic [W-1:0] cmd_q;

    // Clear only happens while pending, so it never races a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            drop_q    <= 1'b0;
            cmd_q     <= '0;
        end else begin
            drop_q <= valid_i & pending_q;
            if (clear_i) begin
                pending_q <= 1'b0;
            end else if (valid_i && !pending_q) begin
                pending_q <= 1'b1;
                cmd_q     <= data_i;
            end
        end
    end

    assign busy_o = pending_q;
    assign drop_o = drop_q;
    assign cmd_o  = cmd_q;

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter sharing one registered slave bus between two masters,
// with valid/ready sequencing and an optional per-transfer timeout.
module rr_bus_arbiter
    import rr_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = CMD_ADDR_W,
    parameter int unsigned DATA_W  = CMD_DATA_W,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_1,
    input  logic                     in_valid_2,
    input  logic [ADDR_W+DATA_W:0]   data_in_1,
    input  logic [ADDR_W+DATA_W:0]   data_in_2,
    output logic                     busy_1,
    output logic                     busy_2,
    output logic                     drop_1,
    output logic                     drop_2,
    input  logic                     ready_slave1,
    input  logic                     ready_slave2,
    output logic                     valid_slave1,
    output logic                     valid_slave2,
    output logic [ADDR_W-1:0]        addr_out,
    output logic [DATA_W-1:0]        value_out,
    output logic                     handshake_slave1,
    output logic                     handshake_slave2,
    output logic                     grant_id,
    output logic                     timeout_err
);

    localparam int unsigned W        = ADDR_W + DATA_W + 1;
    localparam int unsigned SEL_BIT  = ADDR_W + DATA_W;
    localparam int unsigned ADDR_LSB = DATA_W;
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e           state_q;
    logic             ptr_q;
    logic             valid1_q, valid2_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] value_q;
    logic             grant_q;
    logic             hs1_q, hs2_q, to_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             pend1, pend2;
    logic [W-1:0]     cmd1, cmd2;
    logic             gnt_c, any_c, hs_c, to_hit_c, finish_c;
    logic [W-1:0]     cmd_c;

    rr_req_slot #(.W(W)) u_slot_1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (in_valid_1),
        .data_i  (data_in_1),
        .clear_i (finish_c & ~grant_q),
        .busy_o  (pend1),
        .drop_o  (drop_1),
        .cmd_o   (cmd1)
    );

    rr_req_slot #(.W(W)) u_slot_2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (in_valid_2),
        .data_i  (data_in_2),
        .clear_i (finish_c & grant_q),
        .busy_o  (pend2),
        .drop_o  (drop_2),
        .cmd_o   (cmd2)
    );

    // Grant selection and end-of-transfer detection.
    always_comb begin
        any_c    = pend1 | pend2;
        gnt_c    = (pend1 && pend2) ? ptr_q : !pend1;
        cmd_c    = gnt_c ? cmd2 : cmd1;
        hs_c     = (state_q == ST_SEND) &&
                   ((valid1_q && ready_slave1) || (valid2_q && ready_slave2));
        to_hit_c = (TIMEOUT != 0) && (state_q == ST_SEND) && !hs_c &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));
        finish_c = hs_c | to_hit_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            addr_q   <= '0;
            value_q  <= '0;
            grant_q  <= 1'b0;
            hs1_q    <= 1'b0;
            hs2_q    <= 1'b0;
            to_err_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            hs1_q    <= 1'b0;
            hs2_q    <= 1'b0;
            to_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_c) begin
                        state_q  <= ST_SEND;
                        grant_q  <= gnt_c;
                        addr_q   <= cmd_c[ADDR_LSB +: ADDR_W];
                        value_q  <= cmd_c[0 +: DATA_W];
                        valid1_q <= !cmd_c[SEL_BIT];
                        valid2_q <= cmd_c[SEL_BIT];
                        cnt_q    <= '0;
                    end
                end
                ST_SEND: begin
                    if (finish_c) begin
                        state_q  <= ST_DONE;
                        valid1_q <= 1'b0;
                        valid2_q <= 1'b0;
                        ptr_q    <= !grant_q;
                        if (hs_c) begin
                            hs1_q <= valid1_q;
                            hs2_q <= valid2_q;
                        end else begin
                            to_err_q <= 1'b1;
                        end
                    end else if (TIMEOUT != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign valid_slave1     = valid1_q;
    assign valid_slave2     = valid2_q;
    assign addr_out         = addr_q;
    assign value_out        = value_q;
    assign grant_id         = grant_q;
    assign handshake_slave1 = hs1_q;
    assign handshake_slave2 = hs2_q;
    assign timeout_err      = to_err_q;
    assign busy_1           = pend1;
    assign busy_2           = pend2;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed self-checking bench for rr_bus_arbiter (TIMEOUT = 8).
module tb_rr_bus_arbiter;
    import rr_bus_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid_1 = 1'b0, in_valid_2 = 1'b0;
    cmd_t       data_in_1, data_in_2;
    logic       busy_1, busy_2, drop_1, drop_2;
    logic       ready_slave1 = 1'b0, ready_slave2 = 1'b0;
    logic       valid_slave1, valid_slave2;
    logic [2:0] addr_out, value_out;
    logic       handshake_slave1, handshake_slave2, grant_id, timeout_err;

    int checks = 0;
    int errors = 0;

    rr_bus_arbiter #(.ADDR_W(3), .DATA_W(3), .TIMEOUT(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid_1       (in_valid_1),
        .in_valid_2       (in_valid_2),
        .data_in_1        (data_in_1),
        .data_in_2        (data_in_2),
        .busy_1           (busy_1),
        .busy_2           (busy_2),
        .drop_1           (drop_1),
        .drop_2           (drop_2),
        .ready_slave1     (ready_slave1),
        .ready_slave2     (ready_slave2),
        .valid_slave1     (valid_slave1),
        .valid_slave2     (valid_slave2),
        .addr_out         (addr_out),
        .value_out        (value_out),
        .handshake_slave1 (handshake_slave1),
        .handshake_slave2 (handshake_slave2),
        .grant_id         (grant_id),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic sel, input logic [2:0] a, input logic [2:0] v);
        cmd_t c;
        c.sel = sel; c.addr = a; c.value = v;
        return c;
    endfunction

    // Advance one cycle; sample and drive 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy_1 || busy_2) && n < 60) begin
            cyc();
            n++;
        end
        chk("drain", 32'(busy_1 | busy_2), 32'd0);
        cyc(); cyc();
    endtask

    initial begin
        int vcnt, tcnt, hcnt, tidx;
        data_in_1 = '0; data_in_2 = '0;
        #1;
        // Reset state
        chk("rst_valid", 32'({valid_slave1, valid_slave2}), 32'd0);
        chk("rst_busy", 32'({busy_1, busy_2, drop_1, drop_2}), 32'd0);
        chk("rst_bus", 32'({addr_out, value_out, grant_id}), 32'd0);
        chk("rst_pulse", 32'({handshake_slave1, handshake_slave2, timeout_err}), 32'd0);
        do_reset();

        // Single master 1 transfer, slave 1 always ready
        ready_slave1 = 1'b1;
        data_in_1 = mk(1'b0, 3'd5, 3'd3); in_valid_1 = 1'b1;
        cyc(); in_valid_1 = 1'b0;
        chk("t1_busy_n1", 32'(busy_1), 32'd1);
        chk("t1_valid_n1", 32'(valid_slave1), 32'd0);
        cyc();
        chk("t1_valid_n2", 32'({valid_slave1, valid_slave2}), 32'b10);
        chk("t1_addr_val", 32'({addr_out, value_out}), 32'({3'd5, 3'd3}));
        cyc();
        chk("t1_hs_n3", 32'({handshake_slave1, valid_slave1, busy_1}), 32'b100);
        cyc();
        chk("t1_hs_once", 32'(handshake_slave1), 32'd0);
        chk("t1_addr_hold", 32'(addr_out), 32'd5);
        drain();

        // Simultaneous strobes: m1 then m2, pointer then favours m1 again
        do_reset();
        ready_slave1 = 1'b1; ready_slave2 = 1'b1;
        data_in_1 = mk(1'b0, 3'd1, 3'd2); data_in_2 = mk(1'b1, 3'd6, 3'd5);
        in_valid_1 = 1'b1; in_valid_2 = 1'b1;
        cyc(); in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        chk("t2_busy", 32'({busy_1, busy_2}), 32'b11);
        cyc();
        chk("t2_first", 32'({valid_slave1, valid_slave2, grant_id, addr_out}), 32'({3'b100, 3'd1}));
        cyc();
        chk("t2_hs1", 32'({handshake_slave1, busy_1, busy_2}), 32'b101);
        cyc();
        chk("t2_gap", 32'({valid_slave1, valid_slave2}), 32'd0);
        cyc();
        chk("t2_second", 32'({valid_slave1, valid_slave2, grant_id, addr_out, value_out}),
            32'({3'b011, 3'd6, 3'd5}));
        cyc();
        chk("t2_hs2", 32'({handshake_slave2, handshake_slave1, busy_2}), 32'b100);
        data_in_1 = mk(1'b0, 3'd2, 3'd4); data_in_2 = mk(1'b1, 3'd7, 3'd1);
        in_valid_1 = 1'b1; in_valid_2 = 1'b1;
        cyc(); in_valid_1 = 1'b0; in_valid_2 = 1'b0;
        cyc();
        chk("t2_pair2_first", 32'({valid_slave1, grant_id, addr_out}), 32'({2'b10, 3'd2}));
        cyc(); cyc(); cyc();
        chk("t2_pair2_second", 32'({valid_slave2, grant_id, addr_out}), 32'({2'b11, 3'd7}));
        drain();

        // Timeout on slave 2
        do_reset();
        ready_slave1 = 1'b1; ready_slave2 = 1'b0;
        data_in_2 = mk(1'b1, 3'd3, 3'd3); in_valid_2 = 1'b1;
        cyc(); in_valid_2 = 1'b0;
        cyc();
        vcnt = 0; tcnt = 0; hcnt = 0; tidx = -1;
        for (int i = 0; i < 12; i++) begin
            vcnt += int'(valid_slave2);
            tcnt += int'(timeout_err);
            hcnt += int'(handshake_slave1 | handshake_slave2);
            if (timeout_err && tidx < 0) tidx = i;
            cyc();
        end
        chk("t3_valid_cycles", 32'(vcnt), 32'd8);
        chk("t3_timeout_pulses", 32'(tcnt), 32'd1);
        chk("t3_timeout_when", 32'(tidx), 32'd8);
        chk("t3_no_hs", 32'(hcnt), 32'd0);
        chk("t3_busy_clr", 32'(busy_2), 32'd0);

        // Repeat strobe while busy is dropped; original command is sent
        do_reset();
        ready_slave1 = 1'b0; ready_slave2 = 1'b0;
        data_in_1 = mk(1'b0, 3'd3, 3'd6); in_valid_1 = 1'b1;
        cyc();
        data_in_1 = mk(1'b0, 3'd1, 3'd1);
        cyc(); in_valid_1 = 1'b0;
        chk("t4_drop", 32'(drop_1), 32'd1);
        chk("t4_orig_cmd", 32'({valid_slave1, addr_out, value_out}), 32'({1'b1, 3'd3, 3'd6}));
        cyc();
        chk("t4_drop_once", 32'(drop_1), 32'd0);
        ready_slave1 = 1'b1;
        cyc();
        chk("t4_hs", 32'({handshake_slave1, addr_out, value_out}), 32'({1'b1, 3'd3, 3'd6}));
        drain();

        // Non-selected slave ready is ignored
        do_reset();
        ready_slave1 = 1'b0; ready_slave2 = 1'b1;
        data_in_1 = mk(1'b0, 3'd4, 3'd2); in_valid_1 = 1'b1;
        cyc(); in_valid_1 = 1'b0;
        cyc();
        hcnt = 0;
        for (int i = 0; i < 3; i++) begin
            hcnt += int'(handshake_slave1 | handshake_slave2);
            cyc();
        end
        chk("t5_no_hs", 32'(hcnt), 32'd0);
        chk("t5_held", 32'({valid_slave1, valid_slave2, addr_out}), 32'({2'b10, 3'd4}));
        ready_slave1 = 1'b1;
        cyc();
        chk("t5_hs", 32'({handshake_slave1, handshake_slave2, valid_slave1}), 32'b100);
        drain();

        // Asynchronous reset mid-SEND
        ready_slave1 = 1'b0;
        data_in_1 = mk(1'b0, 3'd6, 3'd7); in_valid_1 = 1'b1;
        cyc(); in_valid_1 = 1'b0;
        cyc(); cyc();
        chk("t6_in_send", 32'(valid_slave1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'({valid_slave1, valid_slave2, busy_1}), 32'd0);
        chk("t6_async_bus", 32'({addr_out, value_out, grant_id}), 32'd0);
        #2 rst_n = 1'b1;
        ready_slave1 = 1'b1;
        cyc();
        chk("t6_no_hs", 32'({handshake_slave1, timeout_err}), 32'd0);
        data_in_1 = mk(1'b0, 3'd2, 3'd2); in_valid_1 = 1'b1;
        cyc(); in_valid_1 = 1'b0;
        chk("t6_lat_n1", 32'(valid_slave1), 32'd0);
        cyc();
        chk("t6_lat_n2", 32'({valid_slave1, addr_out}), 32'({1'b1, 3'd2}));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
